// File: rtl/fan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fan_ctrl_pkg
// Shared definitions for the fan controller front end.
//   - fan_state_e   : sampler FSM state encoding
//   - SPI_BITS_DEF  : default raw bits per ADC frame
//   - SCLK_DIV_DEF  : default clk cycles per SCLK half-period
//   - cnt_width()   : counter width able to hold 0..n-1 (never below 1 bit)
// -----------------------------------------------------------------------------
package fan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } fan_state_e;

    localparam int unsigned SPI_BITS_DEF = 32'd8;
    localparam int unsigned SCLK_DIV_DEF = 32'd4;

    // Width of a counter that runs 0..n-1; a single-value counter still gets one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        if (n > 32'd1) begin
            w = $clog2(n);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fan_adc_sampler_if.sv
// -----------------------------------------------------------------------------
// fan_adc_sampler_if
// Read-only SPI (mode 0) link between the sampler and the external ADC.
//   adc_csn  : chip select, active low (master -> ADC)
//   adc_sclk : serial clock, idles low    (master -> ADC)
//   adc_miso : serial data, MSB first     (ADC -> master)
// The master modport is used by fan_adc_sampler, the slave modport by an ADC.
// -----------------------------------------------------------------------------
interface fan_adc_sampler_if;

    logic adc_csn;
    logic adc_sclk;
    logic adc_miso;

    modport master (
        output adc_csn,
        output adc_sclk,
        input  adc_miso
    );

    modport slave (
        input  adc_csn,
        input  adc_sclk,
        output adc_miso
    );

endinterface

// File: rtl/fan_spi_rx.sv
// -----------------------------------------------------------------------------
// fan_spi_rx
// Bit engine for one SPI mode-0 read: generates SPI_BITS SCLK periods, each
// SCLK_DIV cycles low followed by SCLK_DIV cycles high, and shifts MISO in
// MSB first on the cycle SCLK rises. Chip select and frame framing belong to
// the caller.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   start_i      : begin a word; accepted only while idle_o is high
//   miso_i       : serial data from the ADC
//   sclk_o       : serial clock (registered, idles low)
//   idle_o       : no word in progress
//   done_o       : one-cycle pulse in the final cycle of the last high phase;
//                  data_o holds the complete word during that cycle
//   data_o       : received word
// -----------------------------------------------------------------------------
module fan_spi_rx
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned SPI_BITS = SPI_BITS_DEF,
    parameter int unsigned SCLK_DIV = SCLK_DIV_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                miso_i,
    output logic                sclk_o,
    output logic                idle_o,
    output logic                done_o,
    output logic [SPI_BITS-1:0] data_o
);

    localparam int unsigned      DIV_W    = cnt_width(SCLK_DIV);
    localparam int unsigned      BIT_W    = cnt_width(SPI_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 32'd1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SPI_BITS - 32'd1);

    logic                run_q,   run_d;
    logic                sclk_q,  sclk_d;
    logic [DIV_W-1:0]    hcnt_q,  hcnt_d;
    logic [BIT_W-1:0]    bcnt_q,  bcnt_d;
    logic [SPI_BITS-1:0] shreg_q, shreg_d;
    logic                phase_end_s;

    // Half-period boundary and end-of-word decode. done_o is taken from
    // registers only, so the caller can release chip select on the same edge
    // that returns SCLK low.
    always_comb begin
        phase_end_s = run_q && (hcnt_q == DIV_LAST);
        done_o      = phase_end_s && sclk_q && (bcnt_q == BIT_LAST);
    end

    // Next-state logic for SCLK, half-period counter, bit counter and shifter.
    always_comb begin
        run_d   = run_q;
        sclk_d  = sclk_q;
        hcnt_d  = hcnt_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        if (!run_q) begin
            sclk_d = 1'b0;
            if (start_i) begin
                run_d  = 1'b1;
                hcnt_d = '0;
                bcnt_d = '0;
            end else begin
                run_d  = 1'b0;
            end
        end else if (phase_end_s) begin
            hcnt_d = '0;
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
                // Rising edge of SCLK: capture the bit the ADC set up while SCLK was low.
                shreg_d = (shreg_q << 1'b1) | SPI_BITS'(miso_i);
            end else if (bcnt_q == BIT_LAST) begin
                run_d = 1'b0;
            end else begin
                bcnt_d = bcnt_q + BIT_W'(1);
            end
        end else begin
            hcnt_d = hcnt_q + DIV_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_q   <= 1'b0;
            sclk_q  <= 1'b0;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
        end else begin
            run_q   <= run_d;
            sclk_q  <= sclk_d;
            hcnt_q  <= hcnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
        end
    end

    assign sclk_o = sclk_q;
    assign idle_o = ~run_q;
    assign data_o = shreg_q;

endmodule

// File: rtl/fan_adc_sampler.sv
// -----------------------------------------------------------------------------
// fan_adc_sampler
// Front end of the fan controller: triggers an SPI read of an external ADC
// every SAMPLE_PERIOD clk_en_i ticks, averages 2**AVG_LOG2 conversions and
// presents the top ADC_BITWIDTH bits of the sum with a one-cycle strobe.
// Ports:
//   clk_i            : system clock
//   rst_i            : synchronous reset, active high, overrides everything
//   clk_en_i         : tick enable for the sample-period counter only
//   adc_if           : SPI link to the ADC (csn / sclk / miso), master side
//   ADC_value_o      : averaged, truncated sample; holds between strobes
//   dataVaild_STRB_o : one clk_i pulse when ADC_value_o updates
//   busy_o           : a frame is in progress (csn low or in HOLD)
//   overrun_o        : sticky, a trigger arrived while not idle
// -----------------------------------------------------------------------------
module fan_adc_sampler
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned ADC_BITWIDTH  = 32'd4,
    parameter int unsigned SPI_BITS      = SPI_BITS_DEF,
    parameter int unsigned SCLK_DIV      = SCLK_DIV_DEF,
    parameter int unsigned AVG_LOG2      = 32'd2,
    parameter int unsigned SAMPLE_PERIOD = 32'd1000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clk_en_i,
    fan_adc_sampler_if.master       adc_if,
    output logic [ADC_BITWIDTH-1:0] ADC_value_o,
    output logic                    dataVaild_STRB_o,
    output logic                    busy_o,
    output logic                    overrun_o
);

    localparam int unsigned      ACC_W    = SPI_BITS + AVG_LOG2;
    localparam int unsigned      PER_W    = cnt_width(SAMPLE_PERIOD);
    localparam int unsigned      DIV_W    = cnt_width(SCLK_DIV);
    localparam int unsigned      SMP_W    = AVG_LOG2 + 32'd1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 32'd1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 32'd1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((32'd1 << AVG_LOG2) - 32'd1);

    // Period counter
    logic [PER_W-1:0]        per_q, per_d;
    logic                    trig_s;

    // FSM and datapath
    fan_state_e              state_q, state_d;
    logic [DIV_W-1:0]        wait_q,  wait_d;
    logic [SMP_W-1:0]        smp_q,   smp_d;
    logic [ACC_W-1:0]        acc_q,   acc_d;
    logic [ADC_BITWIDTH-1:0] value_q, value_d;
    logic                    strb_q,  strb_d;
    logic                    csn_q,   csn_d;
    logic                    busy_q,  busy_d;
    logic                    ovr_q,   ovr_d;
    logic                    start_s;

    // SPI bit engine
    logic                    rx_sclk_s;
    logic                    rx_idle_s;
    logic                    rx_done_s;
    logic [SPI_BITS-1:0]     rx_data_s;

    fan_spi_rx #(
        .SPI_BITS (SPI_BITS),
        .SCLK_DIV (SCLK_DIV)
    ) u_spi_rx (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_s),
        .miso_i  (adc_if.adc_miso),
        .sclk_o  (rx_sclk_s),
        .idle_o  (rx_idle_s),
        .done_o  (rx_done_s),
        .data_o  (rx_data_s)
    );

    // Period counter next state; the wrap cycle is the trigger.
    always_comb begin
        trig_s = clk_en_i && (per_q == PER_LAST);
        if (!clk_en_i) begin
            per_d = per_q;
        end else if (per_q == PER_LAST) begin
            per_d = '0;
        end else begin
            per_d = per_q + PER_W'(1);
        end
    end

    // Period counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            per_q <= '0;
        end else begin
            per_q <= per_d;
        end
    end

    // FSM next state, accumulator and output next values.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        smp_d   = smp_q;
        acc_d   = acc_q;
        value_d = value_q;
        strb_d  = 1'b0;
        csn_d   = csn_q;
        busy_d  = busy_q;
        start_s = 1'b0;

        // A trigger is only consumed in IDLE; anywhere else it is lost and flagged.
        if (trig_s && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end else begin
            ovr_d = ovr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (trig_s) begin
                    state_d = ST_SETUP;
                    csn_d   = 1'b0;
                    busy_d  = 1'b1;
                    wait_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (wait_q != DIV_LAST) begin
                    wait_d = wait_q + DIV_W'(1);
                end else if (rx_idle_s) begin
                    // Launch the bit engine so its first low phase follows setup directly.
                    start_s = 1'b1;
                    state_d = ST_SHIFT;
                    wait_d  = '0;
                end else begin
                    wait_d  = wait_q;
                end
            end
            ST_SHIFT: begin
                if (rx_done_s) begin
                    state_d = ST_HOLD;
                    csn_d   = 1'b1;
                    acc_d   = acc_q + ACC_W'(rx_data_s);
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (wait_q != DIV_LAST) begin
                    wait_d = wait_q + DIV_W'(1);
                end else if (smp_q == SMP_LAST) begin
                    wait_d  = '0;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                    // Dropping the low bits of the sum is the divide and the truncation.
                    value_d = acc_q[ACC_W-1 -: ADC_BITWIDTH];
                    strb_d  = 1'b1;
                end else begin
                    wait_d  = '0;
                    busy_d  = 1'b0;
                    smp_d   = smp_q + SMP_W'(1);
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                acc_d   = '0;
                smp_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                csn_d   = 1'b1;
                busy_d  = 1'b0;
                acc_d   = '0;
                smp_d   = '0;
            end
        endcase
    end

    // FSM state, accumulator and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            smp_q   <= '0;
            acc_q   <= '0;
            value_q <= '0;
            strb_q  <= 1'b0;
            csn_q   <= 1'b1;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            smp_q   <= smp_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            strb_q  <= strb_d;
            csn_q   <= csn_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign adc_if.adc_csn   = csn_q;
    assign adc_if.adc_sclk  = rx_sclk_s;
    assign ADC_value_o      = value_q;
    assign dataVaild_STRB_o = strb_q;
    assign busy_o           = busy_q;
    assign overrun_o        = ovr_q;

endmodule

// File: tb/tb_fan_adc_sampler.sv
// -----------------------------------------------------------------------------
// tb_fan_adc_sampler
// Directed bench for fan_adc_sampler. Three instances with defaults except:
//   A: SAMPLE_PERIOD=100, clk_en=1, ADC model replays a word list
//   B: SAMPLE_PERIOD=50,  clk_en=1, MISO tied high (every word 0xFF)
//   C: SAMPLE_PERIOD=20,  clk_en pulsing 1-in-10, MISO tied high
// -----------------------------------------------------------------------------
module tb_fan_adc_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rst_c;
    logic       en_a, en_b, en_c;
    logic [3:0] val_a, val_b, val_c;
    logic       strb_a, strb_b, strb_c;
    logic       busy_a, busy_b, busy_c;
    logic       ovr_a, ovr_b, ovr_c;

    int n_pass  = 0;
    int n_total = 0;

    fan_adc_sampler_if if_a ();
    fan_adc_sampler_if if_b ();
    fan_adc_sampler_if if_c ();

    fan_adc_sampler #(.SAMPLE_PERIOD(100)) u_dut_a (
        .clk_i(clk), .rst_i(rst_a), .clk_en_i(en_a), .adc_if(if_a),
        .ADC_value_o(val_a), .dataVaild_STRB_o(strb_a), .busy_o(busy_a), .overrun_o(ovr_a)
    );
    fan_adc_sampler #(.SAMPLE_PERIOD(50)) u_dut_b (
        .clk_i(clk), .rst_i(rst_b), .clk_en_i(en_b), .adc_if(if_b),
        .ADC_value_o(val_b), .dataVaild_STRB_o(strb_b), .busy_o(busy_b), .overrun_o(ovr_b)
    );
    fan_adc_sampler #(.SAMPLE_PERIOD(20)) u_dut_c (
        .clk_i(clk), .rst_i(rst_c), .clk_en_i(en_c), .adc_if(if_c),
        .ADC_value_o(val_c), .dataVaild_STRB_o(strb_c), .busy_o(busy_c), .overrun_o(ovr_c)
    );

    // ADC model for instance A: next word loaded at csn fall, one bit per SCLK rise.
    logic [7:0] words[$];
    logic [7:0] a_word = 8'h00;
    int         a_idx  = 8;
    always @(negedge if_a.adc_csn) begin
        if (rst_a === 1'b0) begin
            if (words.size() > 0) a_word = words.pop_front();
            else                  a_word = 8'h00;
            a_idx = 0;
        end
    end
    always @(posedge if_a.adc_sclk) a_idx = a_idx + 1;
    assign if_a.adc_miso = (a_idx < 8) ? a_word[7 - a_idx] : 1'b0;
    assign if_b.adc_miso = 1'b1;
    assign if_c.adc_miso = 1'b1;

    // Strobe pulse counter for instance A.
    int sc_a = 0;
    always @(negedge clk) if (strb_a === 1'b1) sc_a = sc_a + 1;

    // clk_en for instance C: high one cycle in every ten.
    initial begin
        en_c = 1'b0;
        forever begin
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                en_c = (i == 9);
            end
        end
    end

    function automatic logic csn_of(input int k);
        case (k)
            0:       return if_a.adc_csn;
            1:       return if_b.adc_csn;
            default: return if_c.adc_csn;
        endcase
    endfunction

    function automatic logic sclk_of(input int k);
        case (k)
            0:       return if_a.adc_sclk;
            1:       return if_b.adc_sclk;
            default: return if_c.adc_sclk;
        endcase
    endfunction

    function automatic logic busy_of(input int k);
        case (k)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic strb_of(input int k);
        case (k)
            0:       return strb_a;
            1:       return strb_b;
            default: return strb_c;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Cycles until csn is low (-1 if the budget runs out).
    task automatic wait_fall(input int k, input int budget, output int n);
        n = 0;
        while (csn_of(k) !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        if (csn_of(k) !== 1'b0) n = -1;
    endtask

    // One frame: gap before csn fall, csn-low length, SCLK rises, cycle of the
    // first rise after the fall, and busy cycles remaining after csn rises.
    task automatic do_frame(input int k, output int gap, output int low,
                            output int rises, output int first, output int tail);
        int   n;
        logic prev;
        low = -1; rises = 0; first = -1; tail = -1;
        wait_fall(k, 1000, gap);
        if (gap >= 0) begin
            low  = 1;
            prev = sclk_of(k);
            n    = 0;
            while (csn_of(k) === 1'b0 && low < 200) begin
                tick();
                n++;
                if (sclk_of(k) === 1'b1 && prev === 1'b0) begin
                    rises++;
                    if (first < 0) first = n;
                end
                prev = sclk_of(k);
                if (csn_of(k) === 1'b0) low++;
            end
            tail = 0;
            while (busy_of(k) === 1'b1 && tail < 50) begin
                tick();
                tail++;
            end
        end
    endtask

    task automatic run_frames(input int k, input int cnt, input string tag);
        int g, l, r, f, t;
        for (int i = 0; i < cnt; i++) begin
            do_frame(k, g, l, r, f, t);
            check({tag, "_csn_low"}, l, 68);
        end
    endtask

    initial begin
        int gap, low, rises, first, tail, n;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        en_a  = 1'b1; en_b  = 1'b1;
        for (int i = 0; i < 4; i++) words.push_back(8'hFF);
        words.push_back(8'h10); words.push_back(8'h20);
        words.push_back(8'h30); words.push_back(8'h40);
        for (int i = 0; i < 4; i++) words.push_back(8'h80);
        words.push_back(8'hFF); words.push_back(8'hFF);
        for (int i = 0; i < 4; i++) words.push_back(8'h80);

        // 1. Reset state and first trigger latency
        repeat (3) tick();
        check("rst_csn",     if_a.adc_csn,  1);
        check("rst_sclk",    if_a.adc_sclk, 0);
        check("rst_value",   val_a,  0);
        check("rst_strobe",  strb_a, 0);
        check("rst_busy",    busy_a, 0);
        check("rst_overrun", ovr_a,  0);
        rst_a = 1'b0;

        // 2. Four 0xFF frames -> 15
        do_frame(0, gap, low, rises, first, tail);
        check("first_fall_cycle", gap,   100);
        check("ff_csn_low",       low,   68);
        check("ff_sclk_rises",    rises, 8);
        check("ff_first_rise",    first, 8);
        check("ff_busy_tail",     tail,  4);
        check("ff_sclk_idle",     if_a.adc_sclk, 0);
        for (int f = 0; f < 2; f++) begin
            do_frame(0, gap, low, rises, first, tail);
            check("ff_gap",   gap,   28);
            check("ff_rises", rises, 8);
        end
        check("no_early_strobe", sc_a, 0);
        do_frame(0, gap, low, rises, first, tail);
        check("ff_strobe", strb_a, 1);
        check("ff_value",  val_a,  15);
        tick();
        check("ff_strobe_width", strb_a, 0);
        check("ff_strobe_count", sc_a,   1);

        // 3. 0x10..0x40 -> 2, then 0x80 x4 -> 8, value holds in between
        run_frames(0, 4, "ramp");
        check("ramp_strobe", strb_a, 1);
        check("ramp_value",  val_a,  2);
        tick();
        run_frames(0, 3, "half");
        check("hold_value",  val_a,  2);
        check("hold_strobe", strb_a, 0);
        run_frames(0, 1, "half");
        check("half_strobe", strb_a, 1);
        check("half_value",  val_a,  8);
        check("a_no_overrun", ovr_a, 0);
        tick();

        // 5. Reset during bit 3 of frame 2, then four fresh 0x80 frames
        run_frames(0, 1, "pre_rst");
        wait_fall(0, 1000, n);
        check("abort_fall_seen", n >= 0, 1);
        repeat (30) tick();
        rst_a = 1'b1;
        tick();
        check("abort_csn",    if_a.adc_csn,  1);
        check("abort_sclk",   if_a.adc_sclk, 0);
        check("abort_busy",   busy_a, 0);
        check("abort_value",  val_a,  0);
        rst_a = 1'b0;
        do_frame(0, gap, low, rises, first, tail);
        check("post_rst_fall", gap, 100);
        check("post_rst_low",  low, 68);
        run_frames(0, 3, "post_rst");
        check("post_rst_strobe", strb_a, 1);
        check("post_rst_value",  val_a,  8);

        // 4. SAMPLE_PERIOD=50: second trigger overruns, averaging still completes
        rst_b = 1'b0;
        wait_fall(1, 1000, n);
        check("b_first_fall", n, 50);
        repeat (49) tick();
        check("b_overrun_before", ovr_b, 0);
        tick();
        check("b_overrun_at_trig2", ovr_b, 1);
        n = 0;
        while (strb_b !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        check("b_strobe_cycle", n, 322);
        check("b_value",        val_b, 15);
        check("b_overrun_sticky", ovr_b, 1);

        // 6. clk_en 1-in-10, SAMPLE_PERIOD=20: triggers every 200 cycles
        rst_c = 1'b0;
        do_frame(2, gap, low, rises, first, tail);
        check("c_csn_low",    low,   68);
        check("c_rises",      rises, 8);
        check("c_first_rise", first, 8);
        for (int f = 0; f < 2; f++) begin
            do_frame(2, gap, low, rises, first, tail);
            check("c_period_gap", gap, 128);
            check("c_csn_low2",   low, 68);
        end
        check("c_no_overrun", ovr_c, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
